// File: rtl/split_pipe_if.sv
// Request/response bus between one master, the split_pipe router and its slave ports.
// The master modport is the requester's view; the slave modport is the router's view.
interface split_pipe_if #(
  parameter int N_SLAVES = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  logic                         m_valid;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic [DATA_W/8-1:0]          m_wstrb;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_ready;
  logic                         m_err;

  logic [N_SLAVES-1:0]          s_valid;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [DATA_W/8-1:0]          s_wstrb;
  logic [N_SLAVES*DATA_W-1:0]   s_rdata;
  logic [N_SLAVES-1:0]          s_ready;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_rdata, m_ready, m_err
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_rdata, m_ready, m_err,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_rdata, s_ready
  );
endinterface

// File: rtl/split_pipe.sv
// Single-outstanding address router: decodes one master request to one of N_SLAVES ports.
// Optional slave wait timeout is enabled by defining SPLIT_PIPE_TIMEOUT_EN.
module split_pipe #(
  parameter int               N_SLAVES    = 3,
  parameter int               ADDR_W      = 32,
  parameter int               DATA_W      = 32,
  parameter int               P_SLAVES    = 31,
  parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEADBEEF,
  parameter int               TIMEOUT_CYC = 255
) (
  input  logic     clk,
  input  logic     rst_n,
  split_pipe_if.slave bus
);

  localparam int SEL_W = $clog2(N_SLAVES);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_in;
  logic              sel_bad;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              timed_out;

  if (N_SLAVES < 2 || N_SLAVES > 16 || P_SLAVES >= ADDR_W || P_SLAVES < SEL_W - 1 ||
      TIMEOUT_CYC < 1 || (DATA_W % 8) != 0) begin : g_bad_params
    $error("split_pipe: illegal parameter combination");
  end

  assign sel_in  = bus.m_addr[P_SLAVES -: SEL_W];
  assign sel_bad = ({1'b0, sel_in} >= (SEL_W + 1)'(N_SLAVES));

  // Only the latched slave's response is ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = bus.s_ready[i];
        sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SPLIT_PIPE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else begin
      if (state == IDLE && bus.m_valid && !sel_bad) begin
        wait_cnt <= '0;
      end else if (state == ACTIVE && !sel_ready && !timed_out) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel_q       <= '0;
      bus.s_valid <= '0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_wstrb <= '0;
      bus.m_ready <= 1'b0;
      bus.m_err   <= 1'b0;
      bus.m_rdata <= '0;
    end else begin
      bus.m_ready <= 1'b0;
      bus.m_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m_valid) begin
            sel_q       <= sel_in;
            bus.s_addr  <= bus.m_addr;
            bus.s_wdata <= bus.m_wdata;
            bus.s_wstrb <= bus.m_wstrb;
            // Unmapped selects skip the slave side and answer straight away.
            if (sel_bad) begin
              bus.m_ready <= 1'b1;
              bus.m_err   <= 1'b1;
              bus.m_rdata <= ERR_DATA;
              state       <= RESP;
            end else begin
              bus.s_valid <= {{(N_SLAVES-1){1'b0}}, 1'b1} << sel_in;
              state       <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (sel_ready) begin
            bus.m_rdata <= sel_rdata;
            bus.m_ready <= 1'b1;
            bus.s_valid <= '0;
            state       <= RESP;
          end else if (timed_out) begin
            bus.m_rdata <= ERR_DATA;
            bus.m_ready <= 1'b1;
            bus.m_err   <= 1'b1;
            bus.s_valid <= '0;
            state       <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/split_pipe.md
SPLIT_PIPE -- requirements
Module: split_pipe

Interface
REQ-001 Parameter N_SLAVES, default 3: number of slave ports; legal range 2..16.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width; wstrb width is DATA_W/8.
REQ-004 Parameter P_SLAVES, default 31: MSB index of the slave-select field in the address; SEL_W=clog2(N_SLAVES); P_SLAVES >= SEL_W-1.
REQ-005 Parameter ERR_DATA, default 32'hDEADBEEF: rdata returned on an error response.
REQ-006 Parameter TIMEOUT_CYC, default 255: slave wait limit in cycles; used only with the timeout feature.
REQ-007 clk  input  1  system clock; all state on rising edge.
REQ-008 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 m_valid/m_addr/m_wdata/m_wstrb  input  1/ADDR_W/DATA_W/DATA_W/8  master request; wstrb==0 means read.
REQ-010 m_rdata/m_ready  output  DATA_W/1  master response.
REQ-011 m_err  output  1  one-cycle pulse coincident with an error response.
REQ-012 s_valid  output  N_SLAVES  per-slave request valid.
REQ-013 s_addr/s_wdata/s_wstrb  output  ADDR_W/DATA_W/DATA_W/8  shared request fields, broadcast to all slaves.
REQ-014 s_rdata/s_ready  input  N_SLAVES*DATA_W/N_SLAVES  per-slave response; slave i occupies slice i.

Function
REQ-015 FSM states: IDLE, ACTIVE, RESP; exactly one transaction in flight.
REQ-016 IDLE with m_valid=1: latch addr, wdata, wstrb and sel=m_addr[P_SLAVES -: SEL_W]; next state ACTIVE, or RESP with error if sel >= N_SLAVES.
REQ-017 ACTIVE: s_valid[sel]=1, all other s_valid bits 0; s_addr/s_wdata/s_wstrb driven from latched values, unchanged while ACTIVE.
REQ-018 ACTIVE with s_ready[sel]=1: capture s_rdata slice sel into m_rdata; next state RESP; s_valid drops the next cycle.
REQ-019 s_ready/s_rdata of non-selected slaves SHALL be ignored in every state.
REQ-020 RESP: m_ready=1 for exactly one cycle; m_rdata stable in that cycle; next state IDLE unconditionally; m_valid ignored in RESP.
REQ-021 Latency: m_valid sampled at cycle 0, s_valid high at cycle 1, s_ready at cycle k>=1 gives m_ready at cycle k+1; minimum 3 cycles per transaction.
REQ-022 Decode error (sel >= N_SLAVES): no s_valid asserted; RESP one cycle after acceptance with m_rdata=ERR_DATA and m_err=1.
REQ-023 m_rdata SHALL hold its last value outside RESP; m_err=0 outside RESP.
REQ-024 Address forwarded unmodified, select bits included.

Reset
REQ-025 While rst=0: state IDLE; s_valid=0, m_ready=0, m_err=0, m_rdata=0, s_addr=0, s_wdata=0, s_wstrb=0, timeout counter=0.
REQ-026 Reset asserted mid-transaction aborts it: s_valid drops asynchronously; no m_ready for the aborted request.
REQ-027 First request is accepted no earlier than the first rising edge after rst returns to 1.

Configuration
REQ-028 Macro SPLIT_PIPE_TIMEOUT_EN defined: a counter of width clog2(TIMEOUT_CYC+1) clears on entry to ACTIVE and increments each ACTIVE cycle without s_ready[sel].
REQ-029 With the macro, when the counter equals TIMEOUT_CYC and s_ready[sel]=0: drop s_valid, go to RESP with m_rdata=ERR_DATA and m_err=1.
REQ-030 With the macro, s_ready[sel] in the same cycle as the count limit wins: the transaction completes normally.
REQ-031 Without the macro: no counter logic; ACTIVE waits indefinitely; m_err is asserted only on decode error.

Verification
REQ-032 N_SLAVES=3, P_SLAVES=31: read at 0x4000_0010, slave1 ready with 0x1234_5678 at cycle 1 -> s_valid=3'b010 at cycle 1, m_ready with m_rdata=0x1234_5678 at cycle 2.
REQ-033 Write 0x8000_0000 with wdata 0xA5A5_A5A5 and wstrb 4'hF, slave2 ready after 4 cycles -> s_wstrb=4'hF stable throughout, one m_ready pulse, m_err=0.
REQ-034 Read at 0xC000_0000 (sel=3, unmapped) -> no s_valid, m_ready and m_err at cycle 1, m_rdata=0xDEADBEEF.
REQ-035 Slave0 ready and slave1 ready both high while sel=0 -> only slave0 rdata returned.
REQ-036 rst=0 at cycle 2 of a pending slave1 access -> s_valid=0 immediately, no m_ready; the next request after release completes normally.
REQ-037 With SPLIT_PIPE_TIMEOUT_EN and TIMEOUT_CYC=8, slave never ready -> s_valid drops after the count limit, then one-cycle m_ready with m_err=1 and m_rdata=0xDEADBEEF; without the macro, s_valid stays high for 100 cycles.
